cache_bus_arbiter: RTL and testbench

- Shares the single snooping bus between NUM_REQ L1 cache control units.
- Each control unit raises bus_req together with bus_req_op (0 = read-miss address phase, 1 = write-back / priority write-back data) and bus_req_clc (tenure length in cycles).
- The arbiter returns a registered one-hot bus_get, holds it for exactly the requested tenure, then inserts a one-cycle bus turnaround.
- Write-backs beat reads; round-robin applies within a class.

---
 rtl/cache_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: grants the shared snooping bus to one of NUM_REQ L1
// cache control units at a time. Write-backs beat read-miss address phases,
// round-robin applies within each class, every tenure lasts the requested
// number of cycles (or ends early if the owner lets go) and is followed by a
// single turnaround cycle.
// Optional build macro: BUS_ARB_AGING_EN -- read requesters that keep losing
// arbitration are promoted into the write-back class so they cannot starve.
module cache_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int CLC_W     = 4,
  parameter int AGE_LIMIT = 3
) (
  input  logic                     plusclk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       bus_req,
  input  logic [NUM_REQ-1:0]       bus_req_op,
  input  logic [NUM_REQ*CLC_W-1:0] bus_req_clc,
  output logic [NUM_REQ-1:0]       bus_get,
  output logic                     bus_busy,
  output logic [2:0]               bus_owner,
  output logic                     tenure_last
);

  // Reject configurations the 3-bit owner index or the 2-bit age counters
  // cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || CLC_W < 1 || AGE_LIMIT < 1 || AGE_LIMIT > 3) begin : g_param_check
    $error("cache_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e             state_q,  state_d;
  logic [CLC_W-1:0]   cnt_q,    cnt_d;
  logic [NUM_REQ-1:0] get_q,    get_d;
  logic               busy_q,   busy_d;
  logic [2:0]         owner_q,  owner_d;
  logic [2:0]         rd_ptr_q, rd_ptr_d;
  logic [2:0]         wb_ptr_q, wb_ptr_d;

  logic [NUM_REQ-1:0] promoted;
  logic [NUM_REQ-1:0] wb_cand;
  logic [NUM_REQ-1:0] rd_cand;
  logic               wb_class;
  logic [2:0]         win_idx;
  logic [2:0]         win_next;
  logic [CLC_W-1:0]   win_clc;
  logic               select_fire;
  logic               owner_req;

  // First set bit of cand at or after ptr, wrapping at NUM_REQ. Scanning the
  // offsets from largest to smallest lets the nearest candidate win.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                         input logic [2:0]         ptr);
    rr_pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (cand[j] && (j == (int'(ptr) + k) % NUM_REQ)) begin
          rr_pick = 3'(j);
        end
      end
    end
  endfunction

`ifdef BUS_ARB_AGING_EN
  logic [NUM_REQ-1:0][1:0] age_q, age_d;

  // A waiting read that has lost AGE_LIMIT times competes as a write-back.
  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      promoted[j] = bus_req[j] & ~bus_req_op[j] & (int'(age_q[j]) >= AGE_LIMIT);
    end
  end

  // Age bookkeeping: clear on grant or withdrawal, count (saturating) every
  // arbitration a pending read loses.
  always_comb begin
    age_d = age_q;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!bus_req[j]) begin
        age_d[j] = 2'd0;
      end else if (select_fire) begin
        if (j == int'(win_idx)) begin
          age_d[j] = 2'd0;
        end else if (!bus_req_op[j] && age_q[j] != 2'd3) begin
          age_d[j] = age_q[j] + 2'd1;
        end
      end
    end
  end

  // Age counter registers.
  always_ff @(posedge plusclk) begin
    // NOTE: the age array is ordinary state that arbitration reads every
    // cycle, so it is reset like any other register rather than left as an
    // unreset memory.
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  // Strict class priority: no read is ever promoted.
  assign promoted = '0;
`endif

  // Class split and winner selection from the live requests.
  always_comb begin
    wb_cand  = (bus_req & bus_req_op) | promoted;
    rd_cand  = bus_req & ~wb_cand;
    wb_class = |wb_cand;
    win_idx  = wb_class ? rr_pick(wb_cand, wb_ptr_q) : rr_pick(rd_cand, rd_ptr_q);
    win_next = 3'((int'(win_idx) + 1) % NUM_REQ);
    win_clc  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j == int'(win_idx)) begin
        win_clc = bus_req_clc[j*CLC_W +: CLC_W];
      end
    end
  end

  // The owner still wants the bus; get_q is one-hot while a tenure runs.
  assign owner_req = |(bus_req & get_q);

  // Next-state logic: IDLE -> GRANT (clc cycles) -> TURN (1 cycle) -> ...
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value held and a latch inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    get_d       = '0;
    owner_d     = owner_q;
    rd_ptr_d    = rd_ptr_q;
    wb_ptr_d    = wb_ptr_q;
    select_fire = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus_req) select_fire = 1'b1;
      end
      ST_GRANT: begin
        if (cnt_q == CLC_W'(1) || !owner_req) begin
          state_d = ST_TURN;
          cnt_d   = '0;
        end else begin
          get_d = get_q;
          cnt_d = cnt_q - CLC_W'(1);
        end
      end
      ST_TURN: begin
        if (|bus_req) select_fire = 1'b1;
        else          state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Op and length are captured only here; later changes are ignored.
    if (select_fire) begin
      state_d = ST_GRANT;
      owner_d = win_idx;
      cnt_d   = (win_clc == '0) ? CLC_W'(1) : win_clc;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == int'(win_idx)) get_d[j] = 1'b1;
      end
      if (wb_class) wb_ptr_d = win_next;
      else          rd_ptr_d = win_next;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any grant with no turnaround.
  always_ff @(posedge plusclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      get_q    <= '0;
      busy_q   <= 1'b0;
      owner_q  <= 3'd0;
      rd_ptr_q <= 3'd0;
      wb_ptr_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      get_q    <= get_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      rd_ptr_q <= rd_ptr_d;
      wb_ptr_q <= wb_ptr_d;
    end
  end

  assign bus_get     = get_q;
  assign bus_busy    = busy_q;
  assign bus_owner   = owner_q;
  assign tenure_last = (state_q == ST_GRANT) && (cnt_q == CLC_W'(1));

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: table-driven scoreboard bench for cache_bus_arbiter.
// Each row gives the inputs applied after one rising edge and the outputs
// expected after the next; the expectation is queued as the row is driven
// and popped once the DUT has clocked it.
module tb_cache_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int CLC_W   = 4;

  logic                     plusclk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       bus_req;
  logic [NUM_REQ-1:0]       bus_req_op;
  logic [NUM_REQ*CLC_W-1:0] bus_req_clc;
  logic [NUM_REQ-1:0]       bus_get;
  logic                     bus_busy;
  logic [2:0]               bus_owner;
  logic                     tenure_last;

  cache_bus_arbiter #(.NUM_REQ(NUM_REQ), .CLC_W(CLC_W), .AGE_LIMIT(3)) dut (
    .plusclk     (plusclk),
    .rst         (rst),
    .bus_req     (bus_req),
    .bus_req_op  (bus_req_op),
    .bus_req_clc (bus_req_clc),
    .bus_get     (bus_get),
    .bus_busy    (bus_busy),
    .bus_owner   (bus_owner),
    .tenure_last (tenure_last)
  );

  always #5 plusclk = ~plusclk;

  typedef struct packed {
    logic [1:0] get;
    logic       busy;
    logic [2:0] owner;
    logic       last;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] req;
    logic [1:0] op;
    logic [3:0] clc1;
    logic [3:0] clc0;
    obs_t       exp;
  } row_t;

  row_t stim_q[$];
  obs_t exp_q[$];
  int   n_checks;
  int   n_fail;

  function automatic void add_row(input int r, input int req, input int op,
                                  input int c1, input int c0, input int get,
                                  input int busy, input int owner, input int last);
    row_t row;
    row.rst       = 1'(r);
    row.req       = 2'(req);
    row.op        = 2'(op);
    row.clc1      = 4'(c1);
    row.clc0      = 4'(c0);
    row.exp.get   = 2'(get);
    row.exp.busy  = 1'(busy);
    row.exp.owner = 3'(owner);
    row.exp.last  = 1'(last);
    stim_q.push_back(row);
  endfunction

  // Drive the next row, queue its expectation, clock once, settle.
  task automatic apply_row();
    row_t row;
    row         = stim_q.pop_front();
    rst         = row.rst;
    bus_req     = row.req;
    bus_req_op  = row.op;
    bus_req_clc = {row.clc1, row.clc0};
    exp_q.push_back(row.exp);
    @(posedge plusclk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    int   k = 0;
    add_row(1, 'b00, 'b00, 0, 0,  'b00, 0, 0, 0);
    add_row(1, 'b11, 'b11, 2, 2,  'b00, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply_row();
      e = exp_q.pop_front();
      o = {bus_get, bus_busy, bus_owner, tenure_last};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got get/busy/owner/last=%b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_single_rd();
    obs_t e, o;
    int   k = 0;
    add_row(0, 'b01, 'b00, 0, 2,  'b01, 1, 0, 0);
    add_row(0, 'b01, 'b00, 0, 2,  'b01, 1, 0, 1);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 0, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply_row();
      e = exp_q.pop_front();
      o = {bus_get, bus_busy, bus_owner, tenure_last};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_rd[%0d]: got get/busy/owner/last=%b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_priority();
    obs_t e, o;
    int   k = 0;
    add_row(0, 'b11, 'b10, 2, 2,  'b10, 1, 1, 0);
    add_row(0, 'b11, 'b10, 2, 2,  'b10, 1, 1, 1);
    add_row(0, 'b01, 'b00, 0, 2,  'b00, 1, 1, 0);
    add_row(0, 'b01, 'b00, 0, 2,  'b01, 1, 0, 0);
    add_row(0, 'b01, 'b00, 0, 2,  'b01, 1, 0, 1);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 0, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply_row();
      e = exp_q.pop_front();
      o = {bus_get, bus_busy, bus_owner, tenure_last};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL priority[%0d]: got get/busy/owner/last=%b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  // The read pointer sits at 1 after cache0's earlier read grants, so
  // cache1 leads the alternation.
  task automatic test_round_robin();
    obs_t e, o;
    int   k = 0;
    add_row(0, 'b11, 'b00, 1, 1,  'b10, 1, 1, 1);
    add_row(0, 'b11, 'b00, 1, 1,  'b00, 1, 1, 0);
    add_row(0, 'b11, 'b00, 1, 1,  'b01, 1, 0, 1);
    add_row(0, 'b11, 'b00, 1, 1,  'b00, 1, 0, 0);
    add_row(0, 'b11, 'b00, 1, 1,  'b10, 1, 1, 1);
    add_row(0, 'b11, 'b00, 1, 1,  'b00, 1, 1, 0);
    add_row(0, 'b11, 'b00, 1, 1,  'b01, 1, 0, 1);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 0, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply_row();
      e = exp_q.pop_front();
      o = {bus_get, bus_busy, bus_owner, tenure_last};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL round_robin[%0d]: got get/busy/owner/last=%b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_early_release();
    obs_t e, o;
    int   k = 0;
    add_row(0, 'b10, 'b10, 4, 0,  'b10, 1, 1, 0);
    add_row(0, 'b10, 'b10, 4, 0,  'b10, 1, 1, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 1, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 1, 0);
    add_row(0, 'b01, 'b00, 0, 0,  'b01, 1, 0, 1);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 0, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply_row();
      e = exp_q.pop_front();
      o = {bus_get, bus_busy, bus_owner, tenure_last};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL early_release[%0d]: got get/busy/owner/last=%b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  // Op and length change mid-tenure; the tenure keeps its captured length 3.
  task automatic test_latched_fields();
    obs_t e, o;
    int   k = 0;
    add_row(0, 'b01, 'b01, 0, 3,  'b01, 1, 0, 0);
    add_row(0, 'b01, 'b00, 0, 1,  'b01, 1, 0, 0);
    add_row(0, 'b01, 'b00, 0, 1,  'b01, 1, 0, 1);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 0, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 0, 0);
    while (stim_q.size() > 0) begin
      apply_row();
      e = exp_q.pop_front();
      o = {bus_get, bus_busy, bus_owner, tenure_last};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL latched_fields[%0d]: got get/busy/owner/last=%b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  // The write-back pointer is 1 going in; after reset a WB tie must go to
  // cache0, and the first grant must follow reset by a single cycle.
  task automatic test_reset_mid();
    obs_t e, o;
    int   k = 0;
    add_row(0, 'b10, 'b00, 3, 0,  'b10, 1, 1, 0);
    add_row(0, 'b10, 'b00, 3, 0,  'b10, 1, 1, 0);
    add_row(1, 'b10, 'b00, 3, 0,  'b00, 0, 0, 0);
    add_row(0, 'b11, 'b11, 2, 2,  'b01, 1, 0, 0);
    add_row(0, 'b11, 'b11, 2, 2,  'b01, 1, 0, 1);
    add_row(0, 'b10, 'b11, 2, 2,  'b00, 1, 0, 0);
    add_row(0, 'b10, 'b11, 2, 2,  'b10, 1, 1, 0);
    add_row(0, 'b10, 'b11, 2, 2,  'b10, 1, 1, 1);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 1, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 1, 0);
    while (stim_q.size() > 0) begin
      apply_row();
      e = exp_q.pop_front();
      o = {bus_get, bus_busy, bus_owner, tenure_last};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got get/busy/owner/last=%b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  // cache1 keeps a 1-cycle write-back pending through every turnaround while
  // cache0 waits with a read.
  task automatic test_aging();
    obs_t e, o;
    int   k = 0;
    add_row(0, 'b11, 'b10, 1, 1,  'b10, 1, 1, 1);
    add_row(0, 'b11, 'b10, 1, 1,  'b00, 1, 1, 0);
    add_row(0, 'b11, 'b10, 1, 1,  'b10, 1, 1, 1);
    add_row(0, 'b11, 'b10, 1, 1,  'b00, 1, 1, 0);
    add_row(0, 'b11, 'b10, 1, 1,  'b10, 1, 1, 1);
    add_row(0, 'b11, 'b10, 1, 1,  'b00, 1, 1, 0);
`ifdef BUS_ARB_AGING_EN
    // Three losses promote cache0; the WB pointer (0) then favours it.
    add_row(0, 'b11, 'b10, 1, 1,  'b01, 1, 0, 1);
    add_row(0, 'b10, 'b10, 1, 1,  'b00, 1, 0, 0);
    add_row(0, 'b10, 'b10, 1, 1,  'b10, 1, 1, 1);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 1, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 1, 0);
`else
    // Strict priority: cache0 waits until the write-back stream stops.
    add_row(0, 'b11, 'b10, 1, 1,  'b10, 1, 1, 1);
    add_row(0, 'b11, 'b10, 1, 1,  'b00, 1, 1, 0);
    add_row(0, 'b01, 'b00, 1, 1,  'b01, 1, 0, 1);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 1, 0, 0);
    add_row(0, 'b00, 'b00, 0, 0,  'b00, 0, 0, 0);
`endif
    while (stim_q.size() > 0) begin
      apply_row();
      e = exp_q.pop_front();
      o = {bus_get, bus_busy, bus_owner, tenure_last};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL aging[%0d]: got get/busy/owner/last=%b expected %b", k, o, e);
      end
      k++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus_req     = '0;
    bus_req_op  = '0;
    bus_req_clc = '0;
    n_checks    = 0;
    n_fail      = 0;
    test_reset();
    test_single_rd();
    test_priority();
    test_round_robin();
    test_early_release();
    test_latched_fields();
    test_reset_mid();
    test_aging();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
